// File: rtl/booth_pkg.sv
// Shared Booth radix-4 action encoding, used by the recoder and the partial-product decoder.
`timescale 1ns/1ps
package booth_pkg;

    // {neg, mag[1:0]}: mag 00 = 0, 01 = x1, 10 = x2
    typedef logic [2:0] booth_act_t;

    localparam booth_act_t ACT_ZERO = 3'b000;
    localparam booth_act_t ACT_P1   = 3'b001;
    localparam booth_act_t ACT_P2   = 3'b010;
    localparam booth_act_t ACT_M1   = 3'b101;
    localparam booth_act_t ACT_M2   = 3'b110;

    typedef enum logic [0:0] {StIdle, StEmit} booth_state_t;

    // Group is {x[2i+1], x[2i], x[2i-1]}
    function automatic booth_act_t booth_recode(input logic [2:0] grp);
        booth_act_t r;
        case (grp)
            3'b001, 3'b010: r = ACT_P1;
            3'b011:         r = ACT_P2;
            3'b100:         r = ACT_M2;
            3'b101, 3'b110: r = ACT_M1;
            default:        r = ACT_ZERO;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/booth_encoder_stream_recode.sv
// Combinational radix-4 Booth digit recoder: one 3-bit group to one action code.
`timescale 1ns/1ps
module booth_digit_recode
    import booth_pkg::*;
(
    input  logic [2:0] grp,
    output booth_act_t act
);

    assign act = booth_recode(grp);

endmodule

// File: rtl/booth_encoder_stream.sv
// Streaming radix-4 Booth recoder: one multiplier word in, one action digit out per cycle.
// Optional BOOTH_ZERO_SKIP_EN suppresses zero digits while keeping true weight indices.
`timescale 1ns/1ps
module booth_encoder_stream
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SIGNED_X = 0,
    localparam int unsigned NDIG    = WIDTH / 2 + 1,
    localparam int unsigned IW      = $clog2(NDIG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    output logic             act_valid,
    input  logic             act_ready,
    output booth_act_t       act,
    output logic [IW-1:0]    act_idx,
    output logic             act_last
);

    localparam int unsigned SW = WIDTH + 3;

    booth_state_t  state_q, state_d;
    logic [SW-1:0] sr_q, sr_d;
    logic [SW-1:0] ext_x;
    logic [IW-1:0] idx_q, idx_d;
    logic          beat;

    // Two extension bits above the MSB, operand, and the implicit x[-1] = 0
    assign ext_x = {(SIGNED_X != 0) ? {2{in_x[WIDTH-1]}} : 2'b00, in_x, 1'b0};

    booth_digit_recode u_recode (
        .grp (sr_q[2:0]),
        .act (act)
    );

    assign act_valid = (state_q == StEmit);
    assign act_idx   = idx_q;
    assign beat      = act_valid && act_ready;
    assign in_ready  = (state_q == StIdle) || (beat && act_last);

`ifdef BOOTH_ZERO_SKIP_EN
    logic [IW-1:0] ld_off, nx_off;

    // Lowest digit index with a nonzero action; 0 when none
    function automatic logic [IW-1:0] first_nz(input logic [SW-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int j = NDIG - 1; j >= 0; j--) begin
            if (booth_recode(v[2*j +: 3]) != ACT_ZERO) r = IW'(j);
        end
        return r;
    endfunction

    function automatic logic any_nz(input logic [SW-1:0] v);
        logic r;
        r = 1'b0;
        for (int j = 0; j < NDIG; j++) begin
            if (booth_recode(v[2*j +: 3]) != ACT_ZERO) r = 1'b1;
        end
        return r;
    endfunction

    assign ld_off   = first_nz(ext_x);
    assign nx_off   = first_nz(sr_q >> 2);
    assign act_last = act_valid && !any_nz(sr_q >> 2);
`else
    assign act_last = act_valid && (idx_q == IW'(NDIG - 1));
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        if (in_valid && in_ready) begin
            state_d = StEmit;
`ifdef BOOTH_ZERO_SKIP_EN
            sr_d    = ext_x >> {ld_off, 1'b0};
            idx_d   = ld_off;
`else
            sr_d    = ext_x;
            idx_d   = '0;
`endif
        end else if (beat) begin
            if (act_last) begin
                state_d = StIdle;
            end else begin
`ifdef BOOTH_ZERO_SKIP_EN
                sr_d  = (sr_q >> 2) >> {nx_off, 1'b0};
                idx_d = idx_q + nx_off + IW'(1);
`else
                sr_d  = sr_q >> 2;
                idx_d = idx_q + IW'(1);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sr_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_booth_encoder_stream.sv
// Directed self-checking bench for booth_encoder_stream (unsigned and signed instances).
`timescale 1ns/1ps
module tb_booth_encoder_stream;

    localparam int unsigned IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          act_ready = 1'b0;
    logic [7:0]    in_x = 8'h00;
    logic          in_ready, act_valid, act_last;
    logic [2:0]    act;
    logic [IW-1:0] act_idx;
    logic          s_in_ready, s_act_valid, s_act_last;
    logic [2:0]    s_act;
    logic [IW-1:0] s_act_idx;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    booth_encoder_stream #(.WIDTH(8), .SIGNED_X(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .act_valid (act_valid),
        .act_ready (act_ready),
        .act       (act),
        .act_idx   (act_idx),
        .act_last  (act_last)
    );

    booth_encoder_stream #(.WIDTH(8), .SIGNED_X(1)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_x      (in_x),
        .act_valid (s_act_valid),
        .act_ready (act_ready),
        .act       (s_act),
        .act_idx   (s_act_idx),
        .act_last  (s_act_last)
    );

    function automatic int act_value(input logic [2:0] a);
        case (a)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b101:  return -1;
            3'b110:  return -2;
            default: return 0;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where the first digit is visible.
    task automatic send(input logic [7:0] x);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_x = x;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({act_valid, act, act_idx, act_last} !== {1'b0, 3'b000, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs got v=%0b act=%b idx=%0d last=%0b required 0/000/0/0",
                     act_valid, act, act_idx, act_last);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%0b required=1", in_ready);
        end
        checks++;
        if (act_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_act_valid got=%0b required=0", act_valid);
        end
    endtask

    task automatic test_zero_stream();
        act_ready = 1'b1;
        send(8'h00);
        for (int b = 0; b < 5; b++) begin
            checks++;
            if ({act_valid, act, act_idx, act_last} !== {1'b1, 3'b000, IW'(b), (b == 4)}) begin
                failures++;
                $display("FAIL zero_beat%0d got v=%0b act=%b idx=%0d last=%0b required 1/000/%0d/%0b",
                         b, act_valid, act, act_idx, act_last, b, (b == 4));
            end
            checks++;
            if (in_ready !== (b == 4)) begin
                failures++;
                $display("FAIL zero_in_ready%0d got=%0b required=%0b", b, in_ready, (b == 4));
            end
            @(negedge clk);
        end
        checks++;
        if (act_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_done_valid got=%0b required=0", act_valid);
        end
    endtask

    task automatic test_patterns();
        logic [7:0] xs [2] = '{8'hFF, 8'h80};
        logic [2:0] exp_u [2][5] = '{'{3'b101, 3'b000, 3'b000, 3'b000, 3'b001},
                                     '{3'b000, 3'b000, 3'b000, 3'b110, 3'b001}};
        logic [2:0] exp_s [5] = '{3'b000, 3'b000, 3'b000, 3'b110, 3'b000};
        act_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            send(xs[c]);
            for (int b = 0; b < 5; b++) begin
                checks++;
                if ({act_valid, act, act_idx} !== {1'b1, exp_u[c][b], IW'(b)}) begin
                    failures++;
                    $display("FAIL pat_%h_beat%0d got v=%0b act=%b idx=%0d required act=%b idx=%0d",
                             xs[c], b, act_valid, act, act_idx, exp_u[c][b], b);
                end
                if (c == 1) begin
                    checks++;
                    if ({s_act_valid, s_act, s_act_idx} !== {1'b1, exp_s[b], IW'(b)}) begin
                        failures++;
                        $display("FAIL signed_80_beat%0d got v=%0b act=%b idx=%0d required act=%b idx=%0d",
                                 b, s_act_valid, s_act, s_act_idx, exp_s[b], b);
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sum;
        logic [2:0] a0;
        logic [IW-1:0] i0;
        logic l0;
        act_ready = 1'b1;
        sum = 0;
        send(8'h5B);
        for (int b = 0; b < 5; b++) begin
            if (b == 2) begin
                a0 = act;
                i0 = act_idx;
                l0 = act_last;
                act_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if ({act_valid, act, act_idx, act_last} !== {1'b1, a0, i0, l0}) begin
                        failures++;
                        $display("FAIL stall_stable got v=%0b act=%b idx=%0d last=%0b required 1/%b/%0d/%0b",
                                 act_valid, act, act_idx, act_last, a0, i0, l0);
                    end
                end
                act_ready = 1'b1;
            end
            checks++;
            if (act_idx !== IW'(b)) begin
                failures++;
                $display("FAIL stall_idx%0d got=%0d required=%0d", b, act_idx, b);
            end
            sum += act_value(act) * (1 << (2 * b));
            if (b == 4) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL last_beat_in_ready got=%0b required=1", in_ready);
                end
                in_valid = 1'b1;
                in_x = 8'h33;
            end
            @(negedge clk);
        end
        checks++;
        if (sum != 91) begin
            failures++;
            $display("FAIL stall_value got=%0d required=91", sum);
        end
        checks++;
        if ({act_valid, act, act_idx} !== {1'b1, 3'b101, 3'd0}) begin
            failures++;
            $display("FAIL no_bubble got v=%0b act=%b idx=%0d required 1/101/0",
                     act_valid, act, act_idx);
        end
        in_valid = 1'b0;
        sum = act_value(act);
        for (int b = 1; b < 5; b++) begin
            @(negedge clk);
            checks++;
            if ({act_valid, act_idx, act_last} !== {1'b1, IW'(b), (b == 4)}) begin
                failures++;
                $display("FAIL b2b_beat%0d got v=%0b idx=%0d last=%0b required 1/%0d/%0b",
                         b, act_valid, act_idx, act_last, b, (b == 4));
            end
            sum += act_value(act) * (1 << (2 * b));
        end
        checks++;
        if (sum != 51) begin
            failures++;
            $display("FAIL b2b_value got=%0d required=51", sum);
        end
        @(negedge clk);
        checks++;
        if (act_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done_valid got=%0b required=0", act_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp [5] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        act_ready = 1'b1;
        send(8'hA7);
        repeat (2) @(negedge clk);
        checks++;
        if (act_idx !== 3'd2) begin
            failures++;
            $display("FAIL mid_idx got=%0d required=2", act_idx);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({act_valid, act_idx} !== {1'b0, 3'd0}) begin
            failures++;
            $display("FAIL async_reset got v=%0b idx=%0d required 0/0", act_valid, act_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({in_ready, act_valid} !== 2'b10) begin
            failures++;
            $display("FAIL post_reset got ready=%0b v=%0b required 1/0", in_ready, act_valid);
        end
        send(8'h01);
        for (int b = 0; b < 5; b++) begin
            checks++;
            if ({act_valid, act, act_idx, act_last} !== {1'b1, exp[b], IW'(b), (b == 4)}) begin
                failures++;
                $display("FAIL after_reset_beat%0d got v=%0b act=%b idx=%0d last=%0b required 1/%b/%0d/%0b",
                         b, act_valid, act, act_idx, act_last, exp[b], b, (b == 4));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_skip();
        act_ready = 1'b1;
        send(8'hFF);
        checks++;
        if ({act_valid, act, act_idx, act_last} !== {1'b1, 3'b101, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL skip_ff_first got v=%0b act=%b idx=%0d last=%0b required 1/101/0/0",
                     act_valid, act, act_idx, act_last);
        end
        @(negedge clk);
        checks++;
        if ({act_valid, act, act_idx, act_last} !== {1'b1, 3'b001, 3'd4, 1'b1}) begin
            failures++;
            $display("FAIL skip_ff_second got v=%0b act=%b idx=%0d last=%0b required 1/001/4/1",
                     act_valid, act, act_idx, act_last);
        end
        @(negedge clk);
        checks++;
        if (act_valid !== 1'b0) begin
            failures++;
            $display("FAIL skip_ff_done got=%0b required=0", act_valid);
        end
        send(8'h00);
        checks++;
        if ({act_valid, act, act_idx, act_last} !== {1'b1, 3'b000, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL skip_zero got v=%0b act=%b idx=%0d last=%0b required 1/000/0/1",
                     act_valid, act, act_idx, act_last);
        end
        @(negedge clk);
        checks++;
        if (act_valid !== 1'b0) begin
            failures++;
            $display("FAIL skip_zero_done got=%0b required=0", act_valid);
        end
    endtask

    initial begin
        test_reset();
`ifdef BOOTH_ZERO_SKIP_EN
        test_zero_skip();
`else
        test_zero_stream();
        test_patterns();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
